// File: rtl/adc_scan_controller.sv
// Scanning controller for the ADC128S022: converts channels 0..NUM_CHANNELS-1 per pass
// and emits one 12-bit sample per channel as a single-cycle valid pulse.
module adc_scan_controller #(
    parameter int unsigned NUM_CHANNELS = 8,
    parameter int unsigned SCLK_DIV     = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        continuous,
    output logic        busy,
    output logic        sample_valid,
    output logic [2:0]  sample_channel,
    output logic [11:0] sample_data,
    output logic        scan_done,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        adc_saddr,
    input  logic        adc_sdat
);

    if (NUM_CHANNELS < 1 || NUM_CHANNELS > 8) begin : g_bad_channels
        $error("adc_scan_controller: NUM_CHANNELS must be in 1..8");
    end
    if (SCLK_DIV < 1) begin : g_bad_div
        $error("adc_scan_controller: SCLK_DIV must be >= 1");
    end

    localparam int unsigned CntW = $clog2(2 * SCLK_DIV);
    localparam logic [CntW-1:0] HalfEnd = CntW'(SCLK_DIV - 1);
    localparam logic [CntW-1:0] BitEnd = CntW'(2 * SCLK_DIV - 1);
    localparam logic [2:0] LastFrame = 3'(NUM_CHANNELS - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      bit_q, bit_d;
    logic [2:0]      frame_q, frame_d;
    logic [11:0]     shift_q, shift_d;
    logic            cap_q, cap_d;
    logic            cs_n_q, cs_n_d;
    logic            sclk_q, sclk_d;
    logic            saddr_q, saddr_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;
    logic [2:0]      chan_q, chan_d;
    logic [11:0]     data_q, data_d;
    logic [3:0]      next_bit;
    logic [2:0]      next_frame;

    // DIN bit for bit b of frame f: the address converted in frame f+1 goes out on bits 2..4.
    function automatic logic addr_bit(input logic [2:0] f, input logic [3:0] b);
        logic [2:0] na;
        na = (f == LastFrame) ? 3'd0 : f + 3'd1;
        case (b)
            4'd2:    return na[2];
            4'd3:    return na[1];
            4'd4:    return na[0];
            default: return 1'b0;
        endcase
    endfunction

    assign next_bit   = bit_q + 4'd1;
    assign next_frame = (bit_q == 4'd15) ? frame_q + 3'd1 : frame_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        shift_d = shift_q;
        cap_d   = 1'b0;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        saddr_d = saddr_q;
        busy_d  = busy_q;
        // The cycle after the last bit of a frame is captured, publish it.
        valid_d = cap_q;
        done_d  = cap_q && (frame_q == LastFrame);
        chan_d  = cap_q ? frame_q : chan_q;
        data_d  = cap_q ? shift_q : data_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSetup;
                    cnt_d   = '0;
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b1;
                    saddr_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            StSetup: begin
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == HalfEnd) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    bit_d   = 4'd0;
                    frame_d = 3'd0;
                    sclk_d  = 1'b0;
                    saddr_d = addr_bit(3'd0, 4'd0);
                end
            end
            StShift: begin
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == HalfEnd) begin
                    sclk_d  = 1'b1;
                    // Leading four zero bits simply fall off the top of the 12-bit register.
                    shift_d = {shift_q[10:0], adc_sdat};
                    cap_d   = (bit_q == 4'd15);
                end
                if (cnt_q == BitEnd) begin
                    cnt_d = '0;
                    if (bit_q == 4'd15 && frame_q == LastFrame) begin
                        state_d = StHold;
                        cs_n_d  = 1'b1;
                    end else begin
                        sclk_d  = 1'b0;
                        bit_d   = next_bit;
                        frame_d = next_frame;
                        saddr_d = addr_bit(next_frame, next_bit);
                    end
                end
            end
            StHold: begin
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == BitEnd) begin
                    cnt_d = '0;
                    if (continuous) begin
                        state_d = StSetup;
                        cs_n_d  = 1'b0;
                    end else begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= 4'd0;
            frame_q <= 3'd0;
            shift_q <= 12'd0;
            cap_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            saddr_q <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            chan_q  <= 3'd0;
            data_q  <= 12'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            shift_q <= shift_d;
            cap_q   <= cap_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            saddr_q <= saddr_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            chan_q  <= chan_d;
            data_q  <= data_d;
        end
    end

    assign busy           = busy_q;
    assign sample_valid   = valid_q;
    assign sample_channel = chan_q;
    assign sample_data    = data_q;
    assign scan_done      = done_q;
    assign adc_cs_n       = cs_n_q;
    assign adc_sclk       = sclk_q;
    assign adc_saddr      = saddr_q;

endmodule

// File: tb/tb_adc_scan_controller.sv
// Bench for adc_scan_controller: three parameterisations, each with an ADC model and a
// cycle-accurate reference derived from the scan timing formulas.
module tb_adc_scan_controller;

    localparam int NI = 3;
    localparam int NS [NI] = '{8, 3, 1};
    localparam int HS [NI] = '{2, 1, 10};

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst_s   [NI];
    logic        start_s [NI];
    logic        cont_s  [NI];
    logic [11:0] tbl     [NI][8];

    int checks = 0;
    int errors = 0;

    // Per-instance observations of the DUT, compared against literals by the main sequence.
    int cycm      [NI];
    int rec_t0    [NI];
    int first_v   [NI];
    int busy_fall [NI];
    int nv        [NI];
    int nd        [NI];
    int nfall     [NI];
    int max_hi    [NI];
    int last_ch   [NI];
    int last_dat  [NI];

    task automatic chk(input int inst, input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL inst%0d %s: got %0d expected %0d at %0t", inst, name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_chk
        localparam int Nch = NS[g];
        localparam int Hd = HS[g];
        localparam int ShiftEnd = 32 * Hd * Nch + Hd;
        localparam int ScanLen = ShiftEnd + 2 * Hd;

        logic        busy, valid, done, cs_n, sclk, saddr, sdat;
        logic [2:0]  ch;
        logic [11:0] dat;

        adc_scan_controller #(
            .NUM_CHANNELS(Nch),
            .SCLK_DIV    (Hd)
        ) u_dut (
            .clock         (clock),
            .reset         (rst_s[g]),
            .start         (start_s[g]),
            .continuous    (cont_s[g]),
            .busy          (busy),
            .sample_valid  (valid),
            .sample_channel(ch),
            .sample_data   (dat),
            .scan_done     (done),
            .adc_cs_n      (cs_n),
            .adc_sclk      (sclk),
            .adc_saddr     (saddr),
            .adc_sdat      (sdat)
        );

        initial begin
            int cyc, t0, rel, q, na, k, hi_run;
            bit active;
            logic e_cs, e_sclk, e_sa, e_busy, e_v, e_d;
            logic p_sclk, p_sa, p_cs, p_busy;
            logic [2:0] hch, ach;
            logic [11:0] hdat;
            logic [15:0] word, din;
            logic [3:0] bc;
            cyc = 0; t0 = 0; active = 0; hch = 0; hdat = 0; hi_run = 0;
            p_sclk = 1; p_sa = 0; p_cs = 1; p_busy = 0;
            ach = 0; word = 0; din = 0; bc = 0; sdat = 0;
            forever begin
                @(negedge clock);
                cyc++;
                cycm[g] = cyc;
                // Reference: inputs seen here are the ones sampled at the edge opening this cycle.
                if (rst_s[g]) begin
                    active = 0; hch = 0; hdat = 0;
                end else if (active && cyc - t0 == ScanLen) begin
                    if (cont_s[g]) t0 = cyc;
                    else active = 0;
                end else if (!active && start_s[g]) begin
                    active = 1; t0 = cyc;
                end
                e_cs = 1; e_sclk = 1; e_sa = 0; e_busy = active; e_v = 0; e_d = 0;
                if (active) begin
                    rel = cyc - t0;
                    if (rel < ShiftEnd) e_cs = 0;
                    if (rel >= Hd && rel < ShiftEnd) begin
                        q = (rel - Hd) / (2 * Hd);
                        e_sclk = ((rel - Hd) % (2 * Hd)) >= Hd;
                        na = (q / 16 + 1 < Nch) ? q / 16 + 1 : 0;
                        if (q % 16 >= 2 && q % 16 <= 4) e_sa = 1'((na >> (4 - q % 16)) & 1);
                    end
                    k = (rel - 1) / (32 * Hd);
                    if (rel >= 1 && (rel - 1) % (32 * Hd) == 0 && k >= 1 && k <= Nch) begin
                        e_v = 1; hch = 3'(k - 1); hdat = tbl[g][k - 1]; e_d = (k == Nch);
                    end
                end
                chk(g, "cs_n", cs_n, e_cs);
                chk(g, "sclk", sclk, e_sclk);
                chk(g, "saddr", saddr, e_sa);
                chk(g, "busy", busy, e_busy);
                chk(g, "sample_valid", valid, e_v);
                chk(g, "scan_done", done, e_d);
                chk(g, "sample_channel", ch, hch);
                chk(g, "sample_data", dat, hdat);
                if (rst_s[g]) begin
                    chk(g, "reset cs_n", cs_n, 1);
                    chk(g, "reset sclk", sclk, 1);
                    chk(g, "reset busy", busy, 0);
                    chk(g, "reset sample_valid", valid, 0);
                end
                // ADC128S022 model: data out on SCLK fall, DIN sampled on SCLK rise.
                if (cs_n) begin
                    bc = 0; ach = 0; sdat = 0;
                end else if (p_sclk && !sclk) begin
                    if (bc == 4'd0) word = {4'($urandom_range(0, 15)), tbl[g][ach]};
                    sdat = word[4'd15 - bc];
                end else if (!p_sclk && sclk) begin
                    chk(g, "saddr stable at SCLK rise", saddr, p_sa);
                    din = {din[14:0], saddr};
                    if (bc == 4'd15) ach = din[13:11];
                    bc = bc + 4'd1;
                end
                if (!cs_n && p_cs && !p_busy) begin
                    rec_t0[g] = cyc; first_v[g] = -1;
                end
                if (valid) begin
                    nv[g]++;
                    if (first_v[g] < 0) first_v[g] = cyc - rec_t0[g];
                    last_ch[g] = int'(ch); last_dat[g] = int'(dat);
                end
                if (done) nd[g]++;
                if (!busy && p_busy) begin
                    busy_fall[g] = cyc - rec_t0[g]; nfall[g]++;
                end
                if (busy && cs_n) hi_run++;
                else hi_run = 0;
                if (hi_run > max_hi[g]) max_hi[g] = hi_run;
                p_sclk = sclk; p_sa = saddr; p_cs = cs_n; p_busy = busy;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic clr(input int i);
        nv[i] = 0; nd[i] = 0; first_v[i] = -1; busy_fall[i] = -1; nfall[i] = 0; max_hi[i] = 0;
    endtask

    task automatic pulse_start(input int i, output int c);
        start_s[i] = 1'b1;
        c = cycm[i];
        tick(1);
        start_s[i] = 1'b0;
    endtask

    initial begin
        int c;
        for (int i = 0; i < NI; i++) begin
            rst_s[i] = 1'b1; start_s[i] = 1'b0; cont_s[i] = 1'b0;
            cycm[i] = 0; rec_t0[i] = 0; last_ch[i] = 0; last_dat[i] = 0;
            for (int k = 0; k < 8; k++) tbl[i][k] = (i == 0) ? 12'(256 + k) : 12'($urandom);
            clr(i);
        end
        tick(3);
        for (int i = 0; i < NI; i++) rst_s[i] = 1'b0;
        tick(2);

        // Single-shot N=8 H=2 with the ADC returning 0x100+ch.
        pulse_start(0, c);
        tick(600);
        chk(0, "cs_n fall latency", rec_t0[0] - c, 1);
        chk(0, "first valid offset", first_v[0], 65);
        chk(0, "valid count", nv[0], 8);
        chk(0, "scan_done count", nd[0], 1);
        chk(0, "busy fall offset", busy_fall[0], 518);
        chk(0, "last channel", last_ch[0], 7);
        chk(0, "last data", last_dat[0], 'h107);
        chk(0, "HOLD length", max_hi[0], 4);

        // start during SHIFT is ignored.
        clr(0);
        pulse_start(0, c);
        tick(100);
        start_s[0] = 1'b1; tick(1); start_s[0] = 1'b0;
        tick(500);
        chk(0, "ignored start: valid count", nv[0], 8);
        chk(0, "ignored start: first valid", first_v[0], 65);
        chk(0, "ignored start: busy fall", busy_fall[0], 518);
        chk(0, "ignored start: idle entries", nfall[0], 1);

        // Reset in frame 3 bit 9, then a fresh scan.
        clr(0);
        pulse_start(0, c);
        tick(230);
        rst_s[0] = 1'b1; tick(2); rst_s[0] = 1'b0;
        tick(2);
        chk(0, "aborted scan valid count", nv[0], 3);
        chk(0, "aborted scan done count", nd[0], 0);
        clr(0);
        pulse_start(0, c);
        tick(600);
        chk(0, "post-reset valid count", nv[0], 8);
        chk(0, "post-reset busy fall", busy_fall[0], 518);

        // Continuous N=3 H=1: three scans then release.
        clr(1);
        cont_s[1] = 1'b1;
        pulse_start(1, c);
        tick(250);
        cont_s[1] = 1'b0;
        tick(150);
        chk(1, "continuous first valid", first_v[1], 33);
        chk(1, "continuous valid count", nv[1], 9);
        chk(1, "continuous scan_done count", nd[1], 3);
        chk(1, "continuous idle entries", nfall[1], 1);
        chk(1, "continuous busy fall", busy_fall[1], 297);
        chk(1, "cs_n high between scans", max_hi[1], 2);

        // N=1 H=10.
        clr(2);
        pulse_start(2, c);
        tick(400);
        chk(2, "N=1 first valid", first_v[2], 321);
        chk(2, "N=1 valid count", nv[2], 1);
        chk(2, "N=1 scan_done count", nd[2], 1);
        chk(2, "N=1 busy fall", busy_fall[2], 350);

        // Randomized scans, data tables, continuous mode and stray start pulses.
        for (int it = 0; it < 8; it++) begin
            int i;
            i = int'($urandom_range(0, NI - 1));
            for (int k = 0; k < 8; k++) tbl[i][k] = 12'($urandom);
            cont_s[i] = 1'($urandom_range(0, 1));
            tick(int'($urandom_range(0, 5)));
            pulse_start(i, c);
            tick(int'($urandom_range(1, 600)));
            start_s[i] = 1'b1; tick(1); start_s[i] = 1'b0;
            cont_s[i] = 1'b0;
            tick(1300);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
